instr_prefetch: RTL and testbench



---
 rtl/instr_prefetch.sv | 68 ++++++
 tb/tb_instr_prefetch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// instr_prefetch: byte FIFO fetch front end assembling opcode(+immediate) instructions
module instr_prefetch #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  IMM_MASK  = 8'h0F,
  parameter logic [7:0]  IMM_MATCH = 8'h0F
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  output logic       ins_valid,
  input  logic       ins_ready,
  output logic [7:0] ins_op,
  output logic [7:0] ins_imm,
  output logic       ins_rimm,
  output logic [7:0] ins_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    fa, head_addr;
  logic          inflight;
  logic [AW:0]   count;
  logic [AW-1:0] rd, wr;
  logic [7:0]    fifo [DEPTH];
  logic [AW+1:0] occ;
  logic [1:0]    npop;
  always_comb begin
    occ       = {1'b0, count} + (AW+2)'(inflight);
    imem_req  = !rst && !redirect && occ < (AW+2)'(DEPTH);
    imem_addr = fa;
    ins_op    = fifo[rd];
    ins_rimm  = (ins_op & IMM_MASK) == IMM_MATCH;
    ins_imm   = ins_rimm ? fifo[rd + AW'(1)] : 8'h00;
    ins_pc    = head_addr;
    ins_valid = !rst && !redirect && (ins_rimm ? count >= (AW+1)'(2) : count != '0);
    npop      = (ins_valid && ins_ready) ? (ins_rimm ? 2'd2 : 2'd1) : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fa        <= '0;
      head_addr <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      rd        <= '0;
      wr        <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (redirect) begin
      fa        <= redirect_addr;
      head_addr <= redirect_addr;
      inflight  <= 1'b0;
      count     <= '0;
      rd        <= '0;
      wr        <= '0;
    end else begin
      if (imem_req) fa <= fa + 8'd1;
      inflight <= imem_req;
      if (inflight) begin
        fifo[wr] <= imem_rdata;
        wr       <= wr + AW'(1);
      end
      rd        <= rd + AW'(npop);
      head_addr <= head_addr + 8'(npop);
      count     <= count + (AW+1)'(inflight) - (AW+1)'(npop);
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed checks of fetch, assembly, stall, redirect, wrap and reset
module tb_instr_prefetch;
  logic       clk, rst, imem_req, redirect, ins_valid, ins_ready, ins_rimm;
  logic [7:0] imem_addr, imem_rdata, redirect_addr, ins_op, ins_imm, ins_pc;
  logic [7:0] pmem [256];
  int errors = 0, checks = 0;

  instr_prefetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_addr(redirect_addr),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_imm(ins_imm), .ins_rimm(ins_rimm), .ins_pc(ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= pmem[imem_addr];

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    rst = 1'b1; redirect = 1'b0; redirect_addr = 8'h00; ins_ready = 1'b1;
    imem_rdata = 8'h00;
    cyc(); #1;
    chk("rst_valid", {7'b0, ins_valid}, 8'h00);
    chk("rst_req", {7'b0, imem_req}, 8'h00);
    chk("rst_op", ins_op, 8'h00);
    chk("rst_pc", ins_pc, 8'h00);
    chk("rst_rimm", {7'b0, ins_rimm}, 8'h00);
    // single-byte stream
    pmem[0] = 8'h10; pmem[1] = 8'h21; pmem[2] = 8'h32;
    cyc(); rst = 1'b0; #1;
    chk("t1_req0", {7'b0, imem_req}, 8'h01);
    chk("t1_addr0", imem_addr, 8'h00);
    chk("t1_valid0", {7'b0, ins_valid}, 8'h00);
    cyc(); #1;
    chk("t1_addr1", imem_addr, 8'h01);
    chk("t1_valid1", {7'b0, ins_valid}, 8'h00);
    cyc(); #1;
    chk("t1_valid2", {7'b0, ins_valid}, 8'h01);
    chk("t1_op0", ins_op, 8'h10);
    chk("t1_pc0", ins_pc, 8'h00);
    chk("t1_rimm0", {7'b0, ins_rimm}, 8'h00);
    cyc(); #1;
    chk("t1_op1", ins_op, 8'h21);
    chk("t1_pc1", ins_pc, 8'h01);
    cyc(); #1;
    chk("t1_op2", ins_op, 8'h32);
    chk("t1_pc2", ins_pc, 8'h02);
    // two-byte instruction
    cyc(); rst = 1'b1;
    pmem[0] = 8'h1F; pmem[1] = 8'hAB; pmem[2] = 8'h05;
    cyc(); rst = 1'b0; #1;
    chk("t2_addr0", imem_addr, 8'h00);
    cyc();
    cyc(); #1;
    chk("t2_half_valid", {7'b0, ins_valid}, 8'h00);
    chk("t2_half_rimm", {7'b0, ins_rimm}, 8'h01);
    cyc(); #1;
    chk("t2_valid", {7'b0, ins_valid}, 8'h01);
    chk("t2_op", ins_op, 8'h1F);
    chk("t2_imm", ins_imm, 8'hAB);
    chk("t2_pc", ins_pc, 8'h00);
    cyc(); #1;
    chk("t2_next_valid", {7'b0, ins_valid}, 8'h01);
    chk("t2_next_op", ins_op, 8'h05);
    chk("t2_next_pc", ins_pc, 8'h02);
    chk("t2_next_imm", ins_imm, 8'h00);
    // stalled consumer fills FIFO then pauses fetch
    cyc(); rst = 1'b1; ins_ready = 1'b0;
    for (int i = 0; i < 8; i++) pmem[i] = 8'h10 + 8'(i);
    cyc(); rst = 1'b0; #1;
    chk("t3_req0", {7'b0, imem_req}, 8'h01);
    chk("t3_addr0", imem_addr, 8'h00);
    for (int i = 1; i < 4; i++) begin
      cyc(); #1;
      chk("t3_req", {7'b0, imem_req}, 8'h01);
      chk("t3_addr", imem_addr, 8'(i));
    end
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("t3_stall_req", {7'b0, imem_req}, 8'h00);
      chk("t3_stall_valid", {7'b0, ins_valid}, 8'h01);
      chk("t3_stall_op", ins_op, 8'h10);
      chk("t3_stall_pc", ins_pc, 8'h00);
    end
    cyc(); ins_ready = 1'b1; #1;
    chk("t3_rel_req", {7'b0, imem_req}, 8'h00);
    cyc(); #1;
    chk("t3_resume_req", {7'b0, imem_req}, 8'h01);
    chk("t3_resume_addr", imem_addr, 8'h04);
    chk("t3_resume_op", ins_op, 8'h11);
    chk("t3_resume_pc", ins_pc, 8'h01);
    // redirect with 3 bytes queued and a response in flight
    cyc(); rst = 1'b1; ins_ready = 1'b0;
    cyc(); rst = 1'b0;
    cyc(); cyc(); cyc();
    cyc(); ins_ready = 1'b1; redirect = 1'b1; redirect_addr = 8'h40; pmem[8'h40] = 8'h55; #1;
    chk("t4_redir_valid", {7'b0, ins_valid}, 8'h00);
    chk("t4_redir_req", {7'b0, imem_req}, 8'h00);
    cyc(); redirect = 1'b0; #1;
    chk("t4_req", {7'b0, imem_req}, 8'h01);
    chk("t4_addr", imem_addr, 8'h40);
    chk("t4_stale_valid", {7'b0, ins_valid}, 8'h00);
    cyc(); #1;
    chk("t4_wait_valid", {7'b0, ins_valid}, 8'h00);
    cyc(); #1;
    chk("t4_valid", {7'b0, ins_valid}, 8'h01);
    chk("t4_op", ins_op, 8'h55);
    chk("t4_pc", ins_pc, 8'h40);
    // redirect near the top of memory, immediate spanning the wrap
    cyc(); redirect = 1'b1; redirect_addr = 8'hFE;
    pmem[8'hFE] = 8'h01; pmem[8'hFF] = 8'h0F; pmem[8'h00] = 8'h77; pmem[8'h01] = 8'h21; #1;
    chk("t5_redir_valid", {7'b0, ins_valid}, 8'h00);
    cyc(); redirect = 1'b0; #1;
    chk("t5_addr_fe", imem_addr, 8'hFE);
    cyc(); #1;
    chk("t5_addr_ff", imem_addr, 8'hFF);
    cyc(); #1;
    chk("t5_addr_wrap", imem_addr, 8'h00);
    chk("t5_op0", ins_op, 8'h01);
    chk("t5_pc0", ins_pc, 8'hFE);
    chk("t5_valid0", {7'b0, ins_valid}, 8'h01);
    cyc(); #1;
    chk("t5_half_valid", {7'b0, ins_valid}, 8'h00);
    cyc(); #1;
    chk("t5_valid1", {7'b0, ins_valid}, 8'h01);
    chk("t5_op1", ins_op, 8'h0F);
    chk("t5_imm1", ins_imm, 8'h77);
    chk("t5_rimm1", {7'b0, ins_rimm}, 8'h01);
    chk("t5_pc1", ins_pc, 8'hFF);
    cyc(); #1;
    chk("t5_pc2", ins_pc, 8'h01);
    chk("t5_op2", ins_op, 8'h21);
    // reset mid-stream
    cyc(); rst = 1'b1; #1;
    chk("t6_rst_valid", {7'b0, ins_valid}, 8'h00);
    chk("t6_rst_req", {7'b0, imem_req}, 8'h00);
    cyc(); rst = 1'b0; #1;
    chk("t6_after_valid", {7'b0, ins_valid}, 8'h00);
    chk("t6_after_addr", imem_addr, 8'h00);
    chk("t6_after_pc", ins_pc, 8'h00);
    cyc(); cyc(); #1;
    chk("t6_valid", {7'b0, ins_valid}, 8'h01);
    chk("t6_op", ins_op, 8'h77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
